// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD encoder (shift-and-add-3), one input bit per clock.
// Out-of-range requests are flagged on error_o in a single cycle without converting.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 7,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      number_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  error_o
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned REG_W = BCD_W + BIN_W;
    localparam int unsigned CMP_W = (BIN_W > 32) ? BIN_W : 32;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned TOP   = BIN_W + 4 * (DIGITS - 1);

    function automatic logic [CMP_W-1:0] max_val_calc();
        logic [CMP_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            v = v * CMP_W'(10) + CMP_W'(9);
        end
        return v;
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = max_val_calc();

    typedef enum logic {IDLE, CONV} state_t;

    state_t             state, state_n;
    logic [REG_W-1:0]   sh, sh_n, shifted;
    logic [REG_W-2:0]   adj;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               valid_n, error_n;
    logic [BCD_W-1:0]   bcd_n;
    logic [CMP_W-1:0]   num_ext;
    logic [3:0]         nib, top_nib;

    // The top nibble's carry-out would be shifted away, so adj drops that bit up front.
    always_comb begin
        adj     = sh[REG_W-2:0];
        nib     = '0;
        for (int unsigned d = 0; d + 1 < DIGITS; d++) begin
            nib = sh[BIN_W + 4*d +: 4];
            adj[BIN_W + 4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        top_nib = sh[TOP +: 4];
        if (top_nib >= 4'd5) begin
            top_nib = top_nib + 4'd3;
        end
        adj[REG_W-2:TOP] = top_nib[2:0];
    end

    assign shifted = {adj, 1'b0};

    always_comb begin
        num_ext              = '0;
        num_ext[BIN_W-1:0]   = number_i;
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        valid_n = 1'b0;
        bcd_n   = bcd_o;
        error_n = error_o;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    if (num_ext > MAX_VAL) begin
                        valid_n = 1'b1;
                        error_n = 1'b1;
                        bcd_n   = '0;
                    end else begin
                        sh_n    = {{BCD_W{1'b0}}, number_i};
                        cnt_n   = CNT_W'(BIN_W);
                        state_n = CONV;
                    end
                end
            end
            CONV: begin
                sh_n  = shifted;
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    valid_n = 1'b1;
                    error_n = 1'b0;
                    bcd_n   = shifted[REG_W-1:BIN_W];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            valid_o <= 1'b0;
            bcd_o   <= '0;
            error_o <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            cnt     <= cnt_n;
            valid_o <= valid_n;
            bcd_o   <= bcd_n;
            error_o <= error_n;
        end
    end

    assign busy_o = (state == CONV);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed scenarios, a full sweep and random
// values, all compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
    localparam int BIN_W   = 7;
    localparam int DIGITS  = 2;
    localparam int MAX_VAL = 99;
    localparam int LAT     = BIN_W + 1;  // edges from driving start to seeing valid

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] number;
    logic       busy;
    logic       valid;
    logic [7:0] bcd;
    logic       error;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .number_i (number),
        .busy_o   (busy),
        .valid_o  (valid),
        .bcd_o    (bcd),
        .error_o  (error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_bcd(input int n);
        logic [7:0] r;
        int v;
        r = '0;
        if (n > MAX_VAL) return r;
        v = n;
        for (int d = 0; d < DIGITS; d++) begin
            r = r | (8'(v % 10) << (4 * d));
            v = v / 10;
        end
        return r;
    endfunction

    // Drives one request and observes; comparisons are made by the callers.
    task automatic run_conv(input int num, output logic [7:0] b, output logic e,
                            output int edges, output logic busy_seen,
                            output logic early_change, output logic pulse_long);
        logic [7:0] prev;
        prev         = bcd;
        edges        = -1;
        busy_seen    = 1'b0;
        early_change = 1'b0;
        start        = 1'b1;
        number       = 7'(num);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (valid) begin
                edges = i;
                break;
            end
            if (bcd !== prev) early_change = 1'b1;
        end
        b = bcd;
        e = error;
        @(posedge clk); #1;
        pulse_long = valid;
    endtask

    task automatic check_conv(input string name, input int num);
        logic [7:0] b;
        logic e, bs, ec, pl;
        int edges;
        run_conv(num, b, e, edges, bs, ec, pl);
        checks++;
        if (b !== ref_bcd(num)) begin
            errors++;
            $display("FAIL %s bcd n=%0d got %h exp %h", name, num, b, ref_bcd(num));
        end
        checks++;
        if (e !== (num > MAX_VAL)) begin
            errors++;
            $display("FAIL %s error n=%0d got %b exp %b", name, num, e, num > MAX_VAL);
        end
        checks++;
        if (edges != ((num > MAX_VAL) ? 1 : LAT)) begin
            errors++;
            $display("FAIL %s latency n=%0d got %0d exp %0d", name, num, edges,
                     (num > MAX_VAL) ? 1 : LAT);
        end
        checks++;
        if (bs !== (num <= MAX_VAL)) begin
            errors++;
            $display("FAIL %s busy_seen n=%0d got %b exp %b", name, num, bs, num <= MAX_VAL);
        end
        checks++;
        if (ec !== 1'b0 || pl !== 1'b0) begin
            errors++;
            $display("FAIL %s partial/pulse n=%0d got early=%b long=%b exp 0 0", name, num, ec, pl);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        number = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, bcd, error} !== 11'b0) begin
            errors++;
            $display("FAIL reset_hold got busy=%b valid=%b bcd=%h err=%b exp 0 0 00 0",
                     busy, valid, bcd, error);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, valid, bcd, error} !== 11'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b valid=%b bcd=%h err=%b exp 0 0 00 0",
                     busy, valid, bcd, error);
        end
    endtask

    task automatic test_normal();
        int vals[5] = '{45, 0, 9, 10, 99};
        foreach (vals[i]) check_conv("normal", vals[i]);
    endtask

    task automatic test_error();
        check_conv("error", 100);
        check_conv("error", 127);
        check_conv("after_error", 57);
    endtask

    task automatic test_ignored_start();
        int pulses = 0;
        logic [7:0] first_bcd = '0;
        int first_edge = -1;
        start = 1'b1; number = 7'd63;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; number = 7'd12;
        @(posedge clk); #1;
        start = 1'b0; number = '0;
        for (int i = 5; i <= 24; i++) begin
            if (valid) begin
                pulses++;
                if (first_edge < 0) begin
                    first_edge = i - 1;
                    first_bcd  = bcd;
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignored_start pulses got %0d exp 1", pulses);
        end
        checks++;
        if (first_bcd !== ref_bcd(63) || first_edge != LAT) begin
            errors++;
            $display("FAIL ignored_start result got bcd=%h edge=%0d exp %h %0d",
                     first_bcd, first_edge, ref_bcd(63), LAT);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1;
        logic [7:0] b1 = '0, b2 = '0;
        logic acc;
        start = 1'b1; number = 7'd38;
        @(posedge clk); #1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                first = i;
                b1 = bcd;
                break;
            end
        end
        number = 7'd81;
        @(posedge clk); #1;
        start = 1'b0;
        acc = busy;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                second = i;
                b2 = bcd;
                break;
            end
        end
        checks++;
        if (first != BIN_W || b1 !== ref_bcd(38)) begin
            errors++;
            $display("FAIL b2b_first got edge=%0d bcd=%h exp %0d %h", first, b1, BIN_W, ref_bcd(38));
        end
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_in_valid_cycle got busy=%b exp 1", acc);
        end
        checks++;
        if (second != BIN_W || b2 !== ref_bcd(81)) begin
            errors++;
            $display("FAIL b2b_second got edge=%0d bcd=%h exp %0d %h", second, b2, BIN_W, ref_bcd(81));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        logic was_busy;
        start = 1'b1; number = 7'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        was_busy = busy;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (was_busy !== 1'b1 || {busy, valid, bcd, error} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset_async got was_busy=%b busy=%b valid=%b bcd=%h err=%b exp 1 0 0 00 0",
                     was_busy, busy, valid, bcd, error);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (valid) pulses++;
        end
        checks++;
        if (pulses != 0 || bcd !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_abort got pulses=%0d bcd=%h exp 0 00", pulses, bcd);
        end
        check_conv("after_reset", 21);
    endtask

    task automatic test_sweep();
        for (int n = 0; n < 128; n++) check_conv("sweep", n);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) check_conv("random", int'($urandom_range(0, 127)));
    endtask

    initial begin
        test_reset();
        test_normal();
        test_error();
        test_ignored_start();
        test_back_to_back();
        test_mid_reset();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
